// File: rtl/cpu_bridge_pkg.sv
// Shared types and sizing helpers for the CPU-side nibble-serial fabric bridge.
// Pure declarations: no logic, no latency, no flow control.
package cpu_bridge_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int RES_BEAT_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic int op_beats(input int w);
    return w / NIBBLE_W;
  endfunction

  function automatic int res_beats(input int w);
    return (w + RES_BEAT_W - 1) / RES_BEAT_W;
  endfunction

endpackage

// File: rtl/cpu_bridge_deser.sv
// Result beat accumulator: shifts 12-bit beats in LSB-first and truncates to RES_WIDTH.
// One beat per beat_vld cycle; last_beat flags the final beat combinationally; no backpressure.
module cpu_bridge_deser
  import cpu_bridge_pkg::*;
#(
  parameter int RES_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beat_vld,
  input  logic [RES_BEAT_W-1:0] beat_dat,
  output logic                  last_beat,
  output logic [RES_WIDTH-1:0]  res_dat
);

  localparam int RB    = res_beats(RES_WIDTH);
  localparam int ACC_W = RB * RES_BEAT_W;
  localparam int CNT_W = (RB > 1) ? $clog2(RB) : 1;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  assign last_beat = beat_vld && (cnt == CNT_W'(RB - 1));
  assign res_dat   = acc[RES_WIDTH-1:0];

  // New beats enter at the top so that after RB beats beat 0 sits at bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (beat_vld) begin
      acc <= (acc >> RES_BEAT_W) | (ACC_W'(beat_dat) << (ACC_W - RES_BEAT_W));
      cnt <= last_beat ? '0 : cnt + CNT_W'(1);
    end
  end

  generate
    if (ACC_W > RES_WIDTH) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^acc[ACC_W-1:RES_WIDTH];
    end
  endgenerate

endmodule

// File: rtl/cpu_fabric_bridge.sv
// CPU operand/result bridge: accept-to-resp_valid = OP_BEATS+FABRIC_LATENCY+RES_BEATS+1 cycles;
// one transaction in flight, req_ready low until the response transfers. CPU_BRIDGE_PERF_EN adds perf_count.
module cpu_fabric_bridge
  import cpu_bridge_pkg::*;
#(
  parameter int OP_WIDTH       = 32,
  parameter int RES_WIDTH      = 32,
  parameter int FABRIC_LATENCY = 2
) (
  input  logic                  UserCLK,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   req_opa,
  input  logic [OP_WIDTH-1:0]   req_opb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RES_WIDTH-1:0]  resp_data,
  output logic [NIBBLE_W-1:0]   opa_o,
  output logic [NIBBLE_W-1:0]   opb_o,
  input  logic [RES_BEAT_W-1:0] res_i,
  output logic                  busy,
  output logic [31:0]           perf_count
);

  localparam int OPB     = op_beats(OP_WIDTH);
  localparam int CNT_MAX = (OPB > FABRIC_LATENCY) ? OPB : FABRIC_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [OP_WIDTH-1:0] opa_sr;
  logic [OP_WIDTH-1:0] opb_sr;
  logic                recv_last;

  // Gated by reset so a request is never seen as accepted while reset is held.
  assign req_ready = (state == ST_IDLE) && !reset;

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      opa_sr     <= '0;
      opb_sr     <= '0;
      opa_o      <= '0;
      opb_o      <= '0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state  <= ST_SEND;
            cnt    <= '0;
            busy   <= 1'b1;
            opa_o  <= req_opa[NIBBLE_W-1:0];
            opb_o  <= req_opb[NIBBLE_W-1:0];
            opa_sr <= req_opa >> NIBBLE_W;
            opb_sr <= req_opb >> NIBBLE_W;
          end
        end
        ST_SEND: begin
          if (cnt == CNT_W'(OPB - 1)) begin
            cnt   <= '0;
            opa_o <= '0;
            opb_o <= '0;
            state <= (FABRIC_LATENCY == 0) ? ST_RECV : ST_WAIT;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            opa_o  <= opa_sr[NIBBLE_W-1:0];
            opb_o  <= opb_sr[NIBBLE_W-1:0];
            opa_sr <= opa_sr >> NIBBLE_W;
            opb_sr <= opb_sr >> NIBBLE_W;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(FABRIC_LATENCY - 1)) begin
            cnt   <= '0;
            state <= ST_RECV;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RECV: begin
          if (recv_last) begin
            state      <= ST_DONE;
            resp_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  cpu_bridge_deser #(
    .RES_WIDTH (RES_WIDTH)
  ) u_deser (
    .clk       (UserCLK),
    .reset     (reset),
    .beat_vld  (state == ST_RECV),
    .beat_dat  (res_i),
    .last_beat (recv_last),
    .res_dat   (resp_data)
  );

`ifdef CPU_BRIDGE_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      perf_q <= '0;
    end else if (resp_valid && resp_ready) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_count = perf_q;
`else
  assign perf_count = '0;
`endif

endmodule

// File: tb/tb_cpu_fabric_bridge.sv
// Bench for cpu_fabric_bridge: instance 0 uses FABRIC_LATENCY=2, instance 1 uses FABRIC_LATENCY=0.
module tb_cpu_fabric_bridge;

  localparam int LAT0 = 2;
`ifdef CPU_BRIDGE_PERF_EN
  localparam int PERF3 = 3;
`else
  localparam int PERF3 = 0;
`endif

  logic        UserCLK;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_opa    [2];
  logic [31:0] req_opb    [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic [3:0]  opa_o      [2];
  logic [3:0]  opb_o      [2];
  logic [11:0] res_i      [2];
  logic        busy       [2];
  logic [31:0] perf_count [2];

  int checks = 0;
  int errors = 0;

  cpu_fabric_bridge #(.OP_WIDTH(32), .RES_WIDTH(32), .FABRIC_LATENCY(LAT0)) dut0 (
    .UserCLK(UserCLK), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_opa(req_opa[0]), .req_opb(req_opb[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
    .opa_o(opa_o[0]), .opb_o(opb_o[0]), .res_i(res_i[0]),
    .busy(busy[0]), .perf_count(perf_count[0])
  );

  cpu_fabric_bridge #(.OP_WIDTH(32), .RES_WIDTH(32), .FABRIC_LATENCY(0)) dut1 (
    .UserCLK(UserCLK), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_opa(req_opa[1]), .req_opb(req_opb[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
    .opa_o(opa_o[1]), .opb_o(opb_o[1]), .res_i(res_i[1]),
    .busy(busy[1]), .perf_count(perf_count[1])
  );

  initial begin
    UserCLK = 1'b0;
    forever #5 UserCLK = ~UserCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          d;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] exp_res;
    int          exp_lat;
    bit          rr;
    int          hold;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one request; acts as the fabric: captures nibbles, adds, returns 12-bit beats.
  task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit rr,
                         input int hold, input string nm);
    logic [31:0] ca, cb;
    logic [35:0] sum;
    int first, lat, idle_err, busy_err, hold_err;
    ca = '0; cb = '0; sum = '0;
    first = 0; idle_err = 0; busy_err = 0; hold_err = 0;
    lat = (d == 0) ? LAT0 : 0;
    @(negedge UserCLK);
    chk({nm, ":req_ready"}, 64'(req_ready[d]), 64'd1);
    req_valid[d]  = 1'b1;
    req_opa[d]    = a;
    req_opb[d]    = b;
    resp_ready[d] = rr;
    for (int c = 1; c <= 40; c++) begin
      @(negedge UserCLK);
      if (c == 1) begin
        req_valid[d] = 1'b0;
        req_opa[d]   = 32'hCAFEF00D;
        req_opb[d]   = 32'h0BADBEEF;
      end
      if (resp_valid[d]) begin
        first = c;
        break;
      end
      if (!busy[d]) busy_err++;
      if (c <= 8) begin
        ca[4*(c-1) +: 4] = opa_o[d];
        cb[4*(c-1) +: 4] = opb_o[d];
      end else if (opa_o[d] != 4'd0 || opb_o[d] != 4'd0) begin
        idle_err++;
      end
      if (c == 8) sum = 36'(ca) + 36'(cb);
      if (c >= 9 + lat && c <= 11 + lat) res_i[d] = sum[12*(c-9-lat) +: 12];
      else res_i[d] = 12'hABC;
    end
    chk({nm, ":latency"}, 64'(first), 64'(exp_lat));
    chk({nm, ":opa_nibbles"}, 64'(ca), 64'(a));
    chk({nm, ":opb_nibbles"}, 64'(cb), 64'(b));
    chk({nm, ":lane_idle"}, 64'(idle_err), 64'd0);
    chk({nm, ":busy"}, 64'(busy_err), 64'd0);
    chk({nm, ":resp_data"}, 64'(resp_data[d]), 64'(exp_res));
    if (!rr) begin
      for (int h = 0; h < hold; h++) begin
        if (resp_data[d] !== exp_res || req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b1)
          hold_err++;
        @(negedge UserCLK);
      end
      if (hold > 0) chk({nm, ":hold"}, 64'(hold_err), 64'd0);
      resp_ready[d] = 1'b1;
    end
    @(negedge UserCLK);
    resp_ready[d] = 1'b0;
    res_i[d]      = 12'd0;
    chk({nm, ":resp_valid_drop"}, 64'(resp_valid[d]), 64'd0);
    chk({nm, ":req_ready_back"}, 64'(req_ready[d]), 64'd1);
  endtask

  initial begin
    vecs[0] = '{0, 32'h12345678, 32'h11111111, 32'h23456789, 14, 1'b1, 0};
    vecs[1] = '{0, 32'h00000000, 32'h00000000, 32'h00000000, 14, 1'b1, 0};
    vecs[2] = '{0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 14, 1'b0, 0};
    vecs[3] = '{0, 32'hDEADBEEF, 32'h01010101, 32'hDFAEBFF0, 14, 1'b0, 5};
    vecs[4] = '{1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 12, 1'b1, 0};
    vecs[5] = '{1, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 12, 1'b1, 0};
    vecs[6] = '{0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 14, 1'b1, 0};
    vecs[7] = '{1, 32'h00000FFF, 32'h00000001, 32'h00001000, 12, 1'b0, 2};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_opa[i] = '0; req_opb[i] = '0;
      resp_ready[i] = 1'b0; res_i[i] = '0;
    end
    repeat (3) @(negedge UserCLK);
    chk("rst:req_ready_in_reset", 64'(req_ready[0]), 64'd0);
    reset = 1'b0;
    @(negedge UserCLK);
    chk("rst:req_ready", 64'(req_ready[0]), 64'd1);
    chk("rst:resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("rst:resp_data", 64'(resp_data[0]), 64'd0);
    chk("rst:opa_o", 64'(opa_o[0]), 64'd0);
    chk("rst:opb_o", 64'(opb_o[0]), 64'd0);
    chk("rst:busy", 64'(busy[0]), 64'd0);
    chk("rst:perf", 64'(perf_count[0]), 64'd0);
    chk("rst:req_ready_lat0", 64'(req_ready[1]), 64'd1);

    for (int i = 0; i < NV; i++)
      run_txn(vecs[i].d, vecs[i].opa, vecs[i].opb, vecs[i].exp_res, vecs[i].exp_lat,
              vecs[i].rr, vecs[i].hold, $sformatf("vec%0d", i));

    // Reset while the fourth operand beat is on the lanes.
    @(negedge UserCLK);
    req_valid[0] = 1'b1; req_opa[0] = 32'hFFFFFFFF; req_opb[0] = 32'hFFFFFFFF;
    @(negedge UserCLK);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge UserCLK);
    chk("midrst:beat3", 64'(opa_o[0]), 64'hF);
    reset = 1'b1;
    @(negedge UserCLK);
    chk("midrst:opa_o", 64'(opa_o[0]), 64'd0);
    chk("midrst:busy", 64'(busy[0]), 64'd0);
    chk("midrst:resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("midrst:req_ready", 64'(req_ready[0]), 64'd0);
    chk("midrst:resp_data", 64'(resp_data[0]), 64'd0);
    reset = 1'b0;
    run_txn(0, 32'h0, 32'h0, 32'h0, 14, 1'b1, 0, "after_rst");

    reset = 1'b1;
    @(negedge UserCLK);
    reset = 1'b0;
    run_txn(0, 32'h00000001, 32'h00000002, 32'h00000003, 14, 1'b1, 0, "perf_a");
    run_txn(0, 32'h10000000, 32'h20000000, 32'h30000000, 14, 1'b1, 0, "perf_b");
    run_txn(0, 32'h00ABCDEF, 32'h00111111, 32'h00BCDF00, 14, 1'b1, 0, "perf_c");
    chk("perf:count3", 64'(perf_count[0]), 64'(PERF3));
    reset = 1'b1;
    @(negedge UserCLK);
    chk("perf:cleared", 64'(perf_count[0]), 64'd0);
    reset = 1'b0;
    @(negedge UserCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fabric_bridge.md
Name: cpu_fabric_bridge

Overview:
- CPU-side endpoint of the nibble-serial operand/result interface on the east CPU IO tiles.
- Accepts one operand pair from the CPU core over a valid/ready handshake and serialises both operands into the fabric as 4-bit beats on the OPA/OPB lanes.
- Waits a fixed fabric latency, then deserialises 12-bit result beats from the three RES lanes and returns the assembled result to the CPU over a valid/ready handshake.
- One transaction in flight at a time.

Parameters:
- OP_WIDTH, 32, operand width in bits; multiple of 4. OP_BEATS = OP_WIDTH/4.
- RES_WIDTH, 32, result width in bits; RES_BEATS = ceil(RES_WIDTH/12).
- FABRIC_LATENCY, 2, idle cycles between the last operand beat and the first result beat; 0 is legal.

Ports:
- UserCLK  in  1  single clock; all state on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge can accept a request.
- req_opa  in  OP_WIDTH  operand A.
- req_opb  in  OP_WIDTH  operand B.
- resp_valid  out  1  result available.
- resp_ready  in  1  CPU accepts the result.
- resp_data  out  RES_WIDTH  assembled result.
- opa_o  out  4  operand A nibble to the fabric OPA lanes (bit i drives OPA_Ii).
- opb_o  out  4  operand B nibble to the fabric OPB lanes.
- res_i  in  12  result beat from the fabric: {RES2_O3..0, RES1_O3..0, RES0_O3..0}; RES0_O0 is bit 0.
- busy  out  1  high in every state except IDLE.
- perf_count  out  32  completed-transaction count (see Optional Feature).

Behaviour:
- Interface decisions: one clock, UserCLK; reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, req_ready=1 from the first cycle after reset deasserts (0 while reset is high), resp_valid=0, resp_data=0, opa_o=0, opb_o=0, busy=0, perf_count=0.
- FSM states: IDLE, SEND, WAIT, RECV, DONE.
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid&req_ready: latch req_opa/req_opb into shift registers, beat counter=0, go to SEND.
- SEND: lasts OP_BEATS cycles.
  - On beat k, opa_o/opb_o carry bits [4k+3:4k] of the latched operands (LSB nibble first). Outputs are registered, so beat 0 appears in the cycle after acceptance.
  - After beat OP_BEATS-1, go to WAIT; if FABRIC_LATENCY=0, go directly to RECV.
- WAIT: lasts FABRIC_LATENCY cycles; opa_o/opb_o=0.
- RECV: lasts RES_BEATS cycles.
  - res_i is sampled each cycle; beat j fills result bits [12j+11:12j].
  - Bits at or above RES_WIDTH are discarded.
  - Then go to DONE.
- DONE:
  - resp_valid=1 and resp_data is stable until resp_valid&resp_ready.
  - On that transfer, go to IDLE with resp_valid=0 in the next cycle.
  - If resp_ready is already high on entry, the transfer completes in the first DONE cycle.
- Latency: acceptance edge to resp_valid high = OP_BEATS+FABRIC_LATENCY+RES_BEATS+1 cycles (14 with defaults).
- Throughput: the next request is accepted no earlier than the cycle after the response transfer; req_valid and resp_ready in the same cycle never overlap (req_ready=0 in DONE).
- Lane idle value: opa_o/opb_o=0 in every state except SEND.
- Bus rules: req_opa/opb are ignored outside acceptance. The CPU may drop req_valid before acceptance with no side effect.
- Reset mid-transaction: abandons the transfer immediately; all outputs return to their reset values; no partial response is ever presented.

Optional Feature:
- Macro: CPU_BRIDGE_PERF_EN.
- Defined: perf_count increments by 1 on each response transfer (resp_valid&resp_ready), wraps 0xFFFFFFFF->0, and clears on reset.
- Undefined: perf_count is tied to 0, no counter flops exist, all other behaviour is identical.

Decomposition:
- Package cpu_bridge_pkg: FSM state enum, NIBBLE_W=4, RES_BEAT_W=12, and OP_BEATS/RES_BEATS helper functions.
- One sub-module, cpu_bridge_deser: the RES beat accumulator (shift register, beat counter, truncation to RES_WIDTH), instantiated once.
- The FSM and serialiser stay in the top level.

Test Plan:
- Fabric model: captures the nibble streams, computes A+B, and after FABRIC_LATENCY drives the 12-bit sum beats LSB first.
- Basic add: opa=0x12345678, opb=0x11111111, resp_ready=1 -> opa_o sequence 8,7,6,5,4,3,2,1; resp_valid in cycle 14 after acceptance; resp_data=0x23456789.
- Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_data held at the same value, req_ready=0 throughout; transfer occurs on the first resp_ready=1 cycle.
- Latency 0: FABRIC_LATENCY=0, opa=0xFFFFFFFF, opb=1 -> first RES sample in the cycle after the last SEND beat; resp_data=0x00000000 (carry truncated); resp_valid at cycle 12.
- Reset mid-SEND: reset asserted at beat 3 -> next cycle opa_o=0, busy=0, resp_valid=0; a new request with opa=opb=0 then yields resp_data=0.
- Perf counter (CPU_BRIDGE_PERF_EN defined): 3 back-to-back transactions -> perf_count=3; reset -> 0; with the macro undefined -> perf_count stays 0.
